// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control FSM
// Contents: opcode/funct constants, ALU op codes, datapath select codes,
// FSM state encodings, instruction-class struct and funct->ALU op helper.
package mc_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ALU srcB select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // Immediate extender modes
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encodings; 4'hC..4'hF are unused and recover to FETCH
  localparam logic [3:0] S_FETCH    = 4'h0;
  localparam logic [3:0] S_DECODE   = 4'h1;
  localparam logic [3:0] S_EXEC_R   = 4'h2;
  localparam logic [3:0] S_R_WB     = 4'h3;
  localparam logic [3:0] S_EXEC_I   = 4'h4;
  localparam logic [3:0] S_I_WB     = 4'h5;
  localparam logic [3:0] S_MEM_ADDR = 4'h6;
  localparam logic [3:0] S_MEM_RD   = 4'h7;
  localparam logic [3:0] S_MEM_WB   = 4'h8;
  localparam logic [3:0] S_MEM_WR   = 4'h9;
  localparam logic [3:0] S_BRANCH   = 4'hA;
  localparam logic [3:0] S_JUMP     = 4'hB;

  // One-hot instruction class produced by mc_decode
  typedef struct packed {
    logic rtype_ok;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic illegal;
  } instr_class_t;

  function automatic logic [1:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath signal bundle
// master: the control FSM (takes opcode/funct/zero, drives controls)
// slave:  the datapath (drives opcode/funct/zero, takes controls)
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ext_op;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output pc_write, pc_write_cond, pc_en, pc_source, iord, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           ext_op, alu_op, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, pc_write_cond, pc_en, pc_source, iord, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           ext_op, alu_op, instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - opcode/funct to one-hot instruction class
// Ports: opcode[5:0], funct[5:0] in; cls (instr_class_t) out. Combinational.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  logic funct_ok;

  always_comb begin
    funct_ok = (funct == FN_ADDU) || (funct == FN_SUBU) ||
               (funct == FN_AND)  || (funct == FN_OR);
    cls = '0;
    cls.rtype_ok = (opcode == OP_RTYPE) && funct_ok;
    cls.ori      = (opcode == OP_ORI);
    cls.lui      = (opcode == OP_LUI);
    cls.lw       = (opcode == OP_LW);
    cls.sw       = (opcode == OP_SW);
    cls.beq      = (opcode == OP_BEQ);
    cls.j        = (opcode == OP_J);
    // R-type with an unsupported funct falls through to illegal too
    cls.illegal  = !(cls.rtype_ok || cls.ori || cls.lui || cls.lw ||
                     cls.sw || cls.beq || cls.j);
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle control FSM for the MIPS-subset core
// Ports: clk, reset (async, active-high) plus bus (mc_ctrl_if.master):
//   in  opcode, funct, zero
//   out pc_write, pc_write_cond, pc_en, pc_source, iord, mem_write, ir_write,
//       reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op,
//       instr_done, illegal
module mc_ctrl
  import mc_defs::*;
(
  input logic        clk,
  input logic        reset,
  mc_ctrl_if.master  bus
);

  logic [3:0]   state;
  logic [3:0]   state_nxt;
  instr_class_t cls;

  logic       pc_write, pc_write_cond, iord, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0] pc_source, alu_src_b, ext_op, alu_op;

  mc_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    ext_op        = EXT_ZERO;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = SRCB_BR;
        ext_op    = EXT_SIGN;
        if      (cls.rtype_ok)        state_nxt = S_EXEC_R;
        else if (cls.ori || cls.lui)  state_nxt = S_EXEC_I;
        else if (cls.lw  || cls.sw)   state_nxt = S_MEM_ADDR;
        else if (cls.beq)             state_nxt = S_BRANCH;
        else if (cls.j)               state_nxt = S_JUMP;
        else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu_op(bus.funct);
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        // lui relies on rs=$0, so rs + (imm<<16) is the upper-immediate load
        if (cls.ori) begin
          ext_op = EXT_ZERO;
          alu_op = ALU_OR;
        end else if (cls.lui) begin
          ext_op = EXT_HIGH;
          alu_op = ALU_ADD;
        end
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        ext_op    = EXT_SIGN;
        if      (cls.lw) state_nxt = S_MEM_RD;
        else if (cls.sw) state_nxt = S_MEM_WR;
        else             state_nxt = S_FETCH;
      end
      S_MEM_RD: begin
        iord      = 1'b1;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes are masked combinationally so nothing fires while reset is held,
  // even though the state register already sits in FETCH.
  assign bus.pc_write      = pc_write      & ~reset;
  assign bus.pc_write_cond = pc_write_cond & ~reset;
  assign bus.pc_en         = (pc_write | (pc_write_cond & bus.zero)) & ~reset;
  assign bus.mem_write     = mem_write     & ~reset;
  assign bus.ir_write      = ir_write      & ~reset;
  assign bus.reg_write     = reg_write     & ~reset;
  assign bus.instr_done    = instr_done    & ~reset;
  assign bus.illegal       = illegal       & ~reset;
  assign bus.pc_source     = pc_source;
  assign bus.iord          = iord;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.ext_op        = ext_op;
  assign bus.alu_op        = alu_op;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS-subset core.
- Sequences the shared 32-bit ALU (ALUop 00 add, 01 sub, 10 and, 11 or) across fetch, decode, execute, memory and write-back.
- One ALU handles PC+4, the branch target, address generation and arithmetic, with no extra adders.
- Sits between the IR (opcode/funct), the ALU Zero flag, and the datapath mux-select and write-enable inputs.

Parameters:
- none; opcode/funct encodings and state codes come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- opcode  in  6  IR[31:26]; valid and stable from DECODE to end of instruction
- funct  in  6  IR[5:0]; same validity as opcode
- zero  in  1  ALU Zero flag, combinational from the current cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero
- pc_en  out  1  pc_write | (pc_write_cond & zero)
- pc_source  out  2  PC input select: 00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28], IR[25:0], 2'b00}
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR load
- reg_write  out  1  GRF write strobe
- reg_dst  out  1  write register select: 0 rt, 1 rd
- mem_to_reg  out  1  GRF write data select: 0 ALUOut, 1 MDR
- alu_src_a  out  1  ALU srcA select: 0 PC, 1 register A
- alu_src_b  out  2  ALU srcB select: 00 register B, 01 constant 4, 10 ext(imm), 11 sign-ext(imm)<<2
- ext_op  out  2  immediate extender mode: 00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_op  out  2  ALU operation, same encoding as the ALU
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unrecognised opcode/funct

Behaviour:
- Moore FSM; all outputs decode from the state register, plus opcode/funct where noted. Outputs not listed for a state are 0.
- While reset is high: state = FETCH and all write strobes forced 0 (pc_write, pc_write_cond, pc_en, mem_write, ir_write, reg_write, instr_done, illegal).
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1 (PC <- PC+4). Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=01, alu_op=00 (branch target into ALUOut). Next state by instruction:
  - R-type (opcode 000000) with funct addu 100001, subu 100011, and 100100, or 100101: EXEC_R
  - ori 001101 / lui 001111: EXEC_I
  - lw 100011 / sw 101011: MEM_ADDR
  - beq 000100: BRANCH
  - j 000010: JUMP
  - anything else: illegal=1, instr_done=1, next FETCH (executed as a nop).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct (addu 00, subu 01, and 10, or 11). Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10.
  - ori: ext_op=00, alu_op=11.
  - lui: ext_op=10, alu_op=00. lui computes rs + (imm<<16); the encoding fixes rs=$0.
  - Next: I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=01, alu_op=00. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1. Next: MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next: FETCH.
- MEM_WR: iord=1, mem_write=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- Latency in cycles, counted from FETCH: R/ori/lui 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Boundary conditions:
  - Reset asserted mid-instruction: immediate return to FETCH, no strobes.
  - First FETCH occurs on the first rising edge after reset deasserts.
  - beq with zero=0: pc_en=0 and the PC holds PC+4.
  - State register encodings outside the defined set: next state FETCH, all strobes 0.

Decomposition:
- Shared package (mc_defs) holds:
  - opcode and funct constants
  - ALUop constants (ADD 00, SUB 01, AND 10, OR 11)
  - ALUSrcB, ext_op and pc_source select codes
  - state encodings
- Sub-module mc_decode (combinational, opcode/funct -> instruction class one-hot: rtype_ok, ori, lui, lw, sw, beq, j, illegal). Used by the FSM for DECODE branching and for EXEC alu_op/ext_op selection.

Test Plan:
- Reset mid-EXEC_R (async pulse, no clk edge) -> state FETCH immediately; reg_write=0. Next edge: ir_write=1, pc_write=1, alu_op=00, alu_src_b=01.
- addu (op 000000, funct 100001) -> states FETCH, DECODE, EXEC_R, R_WB. alu_op=00 in EXEC_R; reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses once.
- lw (100011) then sw (101011) -> lw takes 5 cycles with mem_to_reg=1 and reg_dst=0 in cycle 5. sw takes 4 cycles with iord=1 and mem_write=1 in cycle 4; reg_write never high.
- beq with zero=1, then beq with zero=0 -> in BRANCH, alu_op=01, pc_source=01, and pc_en=1 resp. pc_en=0. Both take 3 cycles.
- ori (001101) and lui (001111) -> in EXEC_I, ori gives ext_op=00/alu_op=11 and lui gives ext_op=10/alu_op=00. Both write rt (reg_dst=0) in cycle 4.
- opcode 111111, then j (000010) -> illegal and instr_done pulse in DECODE and return to FETCH (2 cycles). j gives pc_write=1, pc_source=10 in cycle 3.
